ov5640_cfg_ctrl: RTL

OV5640_CFG_CTRL -- requirements
Module: ov5640_cfg_ctrl

---
 rtl/ov5640_cfg_ctrl_pkg.sv | 37 +++
 rtl/ov5640_cfg_ctrl_timer.sv | 26 ++
 rtl/ov5640_cfg_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/ov5640_cfg_ctrl_pkg.sv
// Shared definitions for the OV5640 power-up and register-table sequencer:
// FSM states, register-table entry layout and the delay-marker address.
package ov5640_cfg_ctrl_pkg;

  typedef enum logic [3:0] {
    S_PWDN,
    S_RST,
    S_SETTLE,
    S_FETCH,
    S_LATCH,
    S_REQ,
    S_WAIT,
    S_DELAY,
    S_DONE,
    S_ERR
  } cfg_state_e;

  localparam int unsigned ROM_ADDR_W = 16;
  localparam int unsigned ROM_VAL_W  = 8;
  localparam int unsigned ROM_DATA_W = ROM_ADDR_W + ROM_VAL_W;
  localparam int unsigned CNT_W      = 32;

  localparam logic [ROM_ADDR_W-1:0] DLY_MARKER = 16'hFFFF;

  function automatic logic [ROM_ADDR_W-1:0] rom_reg_addr(input logic [ROM_DATA_W-1:0] d);
    return d[ROM_DATA_W-1 -: ROM_ADDR_W];
  endfunction

  function automatic logic [ROM_VAL_W-1:0] rom_reg_val(input logic [ROM_DATA_W-1:0] d);
    return d[ROM_VAL_W-1:0];
  endfunction

  function automatic logic is_delay_marker(input logic [ROM_DATA_W-1:0] d);
    return rom_reg_addr(d) == DLY_MARKER;
  endfunction

endpackage

// File: rtl/ov5640_cfg_ctrl_timer.sv
// Single shared wait counter: restarts from zero on reload and flags the
// last cycle of a `limit`-cycle interval (a limit of zero lasts one cycle).
module ov5640_cfg_ctrl_timer
  import ov5640_cfg_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             reload,
  input  logic [CNT_W-1:0] limit,
  output logic             expired
);

  logic [CNT_W-1:0] cnt;

  // Saturates instead of wrapping while parked in a state that never expires.
  always_ff @(posedge clk) begin
    if (rst || reload) begin
      cnt <= '0;
    end else if (cnt != '1) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = ({1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1}) >= {1'b0, limit};

endmodule

// File: rtl/ov5640_cfg_ctrl.sv
// OV5640 bring-up sequencer: power-down/reset pin timing, then walks an
// external register table issuing SCCB writes with NACK retry and delays.
module ov5640_cfg_ctrl
  import ov5640_cfg_ctrl_pkg::*;
#(
  parameter logic [23:0] T_PWDN    = 24'd200_000,
  parameter logic [23:0] T_RST     = 24'd100_000,
  parameter logic [23:0] T_SETTLE  = 24'd2_000_000,
  parameter logic [23:0] DLY_UNIT  = 24'd50_000,
  parameter logic [8:0]  REG_NUM   = 9'd256,
  parameter logic [2:0]  MAX_RETRY = 3'd3
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  cfg_reinit,
  output logic                  cam_pwdn,
  output logic                  cam_rst_n,
  output logic [7:0]            rom_addr,
  input  logic [ROM_DATA_W-1:0] rom_data,
  output logic                  sccb_req,
  output logic [ROM_ADDR_W-1:0] sccb_addr,
  output logic [ROM_VAL_W-1:0]  sccb_wdata,
  input  logic                  sccb_busy,
  input  logic                  sccb_done,
  input  logic                  sccb_nack,
  output logic                  cfg_done,
  output logic                  cfg_err,
  output logic [7:0]            cfg_idx
);

  cfg_state_e       state, state_nxt;
  logic [7:0]       idx, idx_nxt;
  logic [2:0]       retry, retry_nxt;
  logic [CNT_W-1:0] dly_limit;
  logic [CNT_W-1:0] tmr_limit;
  logic             tmr_reload;
  logic             tmr_expired;
  logic             advance;
  logic             last_entry;

  assign last_entry = ({1'b0, idx} == (REG_NUM - 9'd1));

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    retry_nxt = retry;
    tmr_limit = '0;
    sccb_req  = 1'b0;
    advance   = 1'b0;

    case (state)
      S_PWDN: begin
        tmr_limit = CNT_W'(T_PWDN);
        if (tmr_expired) state_nxt = S_RST;
      end
      S_RST: begin
        tmr_limit = CNT_W'(T_RST);
        if (tmr_expired) state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        tmr_limit = CNT_W'(T_SETTLE);
        if (tmr_expired) begin
          state_nxt = S_FETCH;
          idx_nxt   = '0;
          retry_nxt = '0;
        end
      end
      S_FETCH: state_nxt = S_LATCH;
      S_LATCH: state_nxt = is_delay_marker(rom_data) ? S_DELAY : S_REQ;
      S_REQ: begin
        if (!sccb_busy) begin
          sccb_req  = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (sccb_done) begin
          if (!sccb_nack) begin
            advance = 1'b1;
          end else if (retry < MAX_RETRY) begin
            retry_nxt = retry + 3'd1;
            state_nxt = S_FETCH;
          end else begin
            state_nxt = S_ERR;
          end
        end
      end
      S_DELAY: begin
        tmr_limit = dly_limit;
        if (tmr_expired) advance = 1'b1;
      end
      S_DONE: state_nxt = S_DONE;
      S_ERR:  state_nxt = S_ERR;
      default: state_nxt = S_PWDN;
    endcase

    if (advance) begin
      retry_nxt = '0;
      if (last_entry) begin
        state_nxt = S_DONE;
      end else begin
        idx_nxt   = idx + 8'd1;
        state_nxt = S_FETCH;
      end
    end

    // Restart wins over everything, including a request or completion this cycle.
    if (cfg_reinit) begin
      state_nxt = S_PWDN;
      idx_nxt   = '0;
      retry_nxt = '0;
      sccb_req  = 1'b0;
    end
  end

  assign tmr_reload = (state_nxt != state) || cfg_reinit;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state      <= S_PWDN;
      idx        <= '0;
      retry      <= '0;
      sccb_addr  <= '0;
      sccb_wdata <= '0;
      dly_limit  <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      retry <= retry_nxt;
      if (state == S_LATCH && !cfg_reinit) begin
        if (is_delay_marker(rom_data)) begin
          dly_limit <= CNT_W'(rom_reg_val(rom_data)) * CNT_W'(DLY_UNIT);
        end else begin
          sccb_addr  <= rom_reg_addr(rom_data);
          sccb_wdata <= rom_reg_val(rom_data);
        end
      end
    end
  end

  ov5640_cfg_ctrl_timer u_timer (
    .clk     (sys_clk),
    .rst     (sys_rst),
    .reload  (tmr_reload),
    .limit   (tmr_limit),
    .expired (tmr_expired)
  );

  assign cam_pwdn  = (state == S_PWDN);
  assign cam_rst_n = !((state == S_PWDN) || (state == S_RST));
  assign cfg_done  = (state == S_DONE);
  assign cfg_err   = (state == S_ERR);
  assign rom_addr  = idx;
  assign cfg_idx   = idx;

endmodule
